// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch datapath.
// Moduli and widths of the centisecond/second/minute digit groups, plus the
// packed time record used for the live count and the lap snapshot.
package stopwatch_pkg;

    localparam int unsigned MSEC_MOD = 100;
    localparam int unsigned SEC_MOD  = 60;
    localparam int unsigned MIN_MOD  = 60;

    localparam int unsigned MSEC_W = 7;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

    // One full time value, most significant group first.
    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
        logic [MSEC_W-1:0] msec;
    } sw_time_t;

    localparam sw_time_t TIME_ZERO = '0;

endpackage

// File: rtl/tick_counter.sv
// Modulo-MOD counter stage of the time cascade.
// Advances by one on i_tick, wraps from MOD-1 to 0 and signals the wrap on
// o_carry in the same cycle so the next stage advances on the same edge.
// i_clear forces the count to 0 and takes priority over i_tick.
module tick_counter #(
    parameter int unsigned MOD   = 10,
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_tick,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_count,
    output logic             o_carry
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_last;

    assign at_last = (count_q == LAST);

    // Next count: clear, wrap at MOD-1, or increment on tick.
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_tick) begin
            count_d = at_last ? '0 : count_q + WIDTH'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_carry = i_tick & at_last;

endmodule

// File: rtl/stopwatch_datapath.sv
// Stopwatch time-keeping datapath.
// A local prescaler divides clk down to a 1/100 s tick while i_run is held and
// i_clear is low; the tick drives a four-stage cascade of tick_counter
// instances (centiseconds, seconds, minutes, hours). A paused prescaler keeps
// its partial progress, so resuming loses no time.
// Optional feature: define STOPWATCH_LAP_EN to enable the lap freeze, where
// i_lap toggles between showing the live count and a snapshot taken on entry.
// Without it, i_lap is ignored and the outputs always show the live count.
module stopwatch_datapath
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1_000_000,
    parameter int unsigned HOUR_MAX = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_run,
    input  logic              i_clear,
    input  logic              i_lap,
    output logic [MSEC_W-1:0] o_msec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic              o_tick
);

    localparam int unsigned    PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               tick;
    logic               tick_q;

    logic               msec_carry;
    logic               sec_carry;
    logic               min_carry;
    logic               unused_hour_carry;

    sw_time_t           live;
    sw_time_t           shown;

    // Prescaler: advance only while running and not clearing; a pause holds
    // the partial tick. Clear wins over run.
    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (i_clear) begin
            presc_d = '0;
        end else if (i_run) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

    // Prescaler and tick-pulse registers; o_tick is registered so it lines
    // up with the count update and has no path from the inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick;
        end
    end

    tick_counter #(
        .MOD   (MSEC_MOD),
        .WIDTH (MSEC_W)
    ) u_msec (
        .clk     (clk),
        .reset   (reset),
        .i_tick  (tick),
        .i_clear (i_clear),
        .o_count (live.msec),
        .o_carry (msec_carry)
    );

    tick_counter #(
        .MOD   (SEC_MOD),
        .WIDTH (SEC_W)
    ) u_sec (
        .clk     (clk),
        .reset   (reset),
        .i_tick  (msec_carry),
        .i_clear (i_clear),
        .o_count (live.sec),
        .o_carry (sec_carry)
    );

    tick_counter #(
        .MOD   (MIN_MOD),
        .WIDTH (MIN_W)
    ) u_min (
        .clk     (clk),
        .reset   (reset),
        .i_tick  (sec_carry),
        .i_clear (i_clear),
        .o_count (live.min),
        .o_carry (min_carry)
    );

    // The hour wrap is the full-day rollover; nothing downstream needs it.
    tick_counter #(
        .MOD   (HOUR_MAX),
        .WIDTH (HOUR_W)
    ) u_hour (
        .clk     (clk),
        .reset   (reset),
        .i_tick  (min_carry),
        .i_clear (i_clear),
        .o_count (live.hour),
        .o_carry (unused_hour_carry)
    );

`ifdef STOPWATCH_LAP_EN
    logic     lap_q;
    logic     lap_d;
    sw_time_t snap_q;
    sw_time_t snap_d;

    // Lap toggle: entering lap captures the pre-edge live count; clear drops
    // both the flag and the snapshot and overrides a coincident i_lap.
    always_comb begin
        lap_d  = lap_q;
        snap_d = snap_q;
        if (i_clear) begin
            lap_d  = 1'b0;
            snap_d = TIME_ZERO;
        end else if (i_lap) begin
            lap_d = ~lap_q;
            if (!lap_q) begin
                snap_d = live;
            end
        end
    end

    // Lap flag and snapshot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            lap_q  <= 1'b0;
            snap_q <= TIME_ZERO;
        end else begin
            lap_q  <= lap_d;
            snap_q <= snap_d;
        end
    end

    assign shown = lap_q ? snap_q : live;
`else
    logic unused_lap;

    assign unused_lap = i_lap;
    assign shown      = live;
`endif

    // All output sources are registers; the lap select is a register too.
    assign o_msec = shown.msec;
    assign o_sec  = shown.sec;
    assign o_min  = shown.min;
    assign o_hour = shown.hour;
    assign o_tick = tick_q;

endmodule
